// File: rtl/sonar_ctrl_if.sv
// Requester-side bus of the sonar controller: measurement request,
// completion pulses and the measured distance.
interface sonar_ctrl_if #(
    parameter int DisLen = 16
);
    logic            trigger;
    logic            triggerSuc;
    logic            valid;
    logic            timeout;
    logic            busy;
    logic [DisLen:0] distance;

    // Requester: raises trigger, observes results
    modport master (
        output trigger,
        input  triggerSuc, valid, timeout, busy, distance
    );

    // Controller: consumes trigger, drives results
    modport slave (
        input  trigger,
        output triggerSuc, valid, timeout, busy, distance
    );
endinterface

// File: rtl/sonar_ctrl.sv
// Ultrasonic range-finder controller: issues the sensor trigger pulse,
// times the echo pulse in DIV-cycle units and reports the distance,
// with timeouts on a missing or stuck echo and an enforced idle gap.
module sonar_ctrl #(
    parameter int DisLen      = 16,
    parameter int TRIG_CYC    = 500,
    parameter int DIV         = 2900,
    parameter int TIMEOUT_CYC = 1900000,
    parameter int GAP_CYC     = 2500000
) (
    input  logic         clk,
    input  logic         rst_n,
    sonar_ctrl_if.slave  bus,
    output logic         sonar_trig,
    input  logic         echo
);

    localparam int CNT_MAX = (TRIG_CYC > TIMEOUT_CYC)
                           ? ((TRIG_CYC > GAP_CYC) ? TRIG_CYC : GAP_CYC)
                           : ((TIMEOUT_CYC > GAP_CYC) ? TIMEOUT_CYC : GAP_CYC);
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam int SW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0]     CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]     TRIG_END = CW'(TRIG_CYC - 1);
    localparam logic [CW-1:0]     TO_END   = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]     GAP_END  = CW'(GAP_CYC - 1);
    localparam logic [SW-1:0]     SUB_ONE  = SW'(1);
    localparam logic [SW-1:0]     SUB_END  = SW'(DIV - 1);
    localparam logic [DisLen:0]   ACC_ONE  = (DisLen + 1)'(1);

    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, ECHO, GAP} state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt;
    logic [SW-1:0]   sub;
    logic [DisLen:0] acc;
    logic            echo_m, echo_s, echo_d;
    logic            rise, fall;

    logic            trig_d, suc_d, valid_d, timeout_d, busy_d;
    logic [DisLen:0] dist_d;

    assign rise = echo_s & ~echo_d;
    assign fall = ~echo_s & echo_d;

    // Two-flop synchronizer for the asynchronous echo plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            echo_m <= 1'b0;
            echo_s <= 1'b0;
            echo_d <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_d <= echo_s;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (bus.trigger) state_next = TRIG;
            TRIG:      if (cnt == TRIG_END) state_next = WAIT_RISE;
            WAIT_RISE: begin
                if (rise)               state_next = ECHO;
                else if (cnt == TO_END) state_next = GAP;
            end
            ECHO:      if (fall || cnt == TO_END) state_next = GAP;
            GAP:       if (cnt == GAP_END) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    // Cycles spent in the current state; restarts on every state change
    always_ff @(posedge clk) begin
        if (!rst_n)                   cnt <= '0;
        else if (state_next != state) cnt <= '0;
        else                          cnt <= cnt + CNT_ONE;
    end

    // Echo-high timing: sub-counter wraps every DIV high cycles into a saturating accumulator
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sub <= '0;
            acc <= '0;
        end else if (state == WAIT_RISE && rise) begin
            // The rise-detect cycle is already the first echo-high cycle,
            // so the cleared counters start with that cycle counted.
            if (DIV == 1) begin
                sub <= '0;
                acc <= ACC_ONE;
            end else begin
                sub <= SUB_ONE;
                acc <= '0;
            end
        end else if (state == ECHO && echo_s) begin
            if (sub == SUB_END) begin
                sub <= '0;
                if (acc != '1) acc <= acc + ACC_ONE;
            end else begin
                sub <= sub + SUB_ONE;
            end
        end
    end

    // Output decode from the upcoming state, registered below
    always_comb begin
        trig_d    = (state_next == TRIG);
        suc_d     = (state == TRIG) && (state_next == WAIT_RISE);
        busy_d    = (state_next != IDLE);
        valid_d   = 1'b0;
        timeout_d = 1'b0;
        dist_d    = bus.distance;
        if (state != GAP && state_next == GAP) begin
            valid_d = 1'b1;
            if (state == ECHO && fall) begin
                dist_d = acc;
            end else begin
                dist_d    = '1;
                timeout_d = 1'b1;
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sonar_trig     <= 1'b0;
            bus.triggerSuc <= 1'b0;
            bus.valid      <= 1'b0;
            bus.timeout    <= 1'b0;
            bus.busy       <= 1'b0;
            bus.distance   <= '0;
        end else begin
            sonar_trig     <= trig_d;
            bus.triggerSuc <= suc_d;
            bus.valid      <= valid_d;
            bus.timeout    <= timeout_d;
            bus.busy       <= busy_d;
            bus.distance   <= dist_d;
        end
    end

endmodule

// File: doc/sonar_ctrl.md
SONAR_CTRL -- requirements
Module: sonar_ctrl

Interface
REQ-001 Parameter DisLen, 16: distance output width is DisLen+1 bits.
REQ-002 Parameter TRIG_CYC, 500: sensor trigger pulse length in clk cycles (10 us at 50 MHz).
REQ-003 Parameter DIV, 2900: clk cycles of echo-high time per distance unit.
REQ-004 Parameter TIMEOUT_CYC, 1900000: maximum cycles spent in WAIT_RISE or in ECHO.
REQ-005 Parameter GAP_CYC, 2500000: minimum idle cycles between the end of one measurement and the next trigger.
REQ-006 clk  in  1  single clock; all logic on its rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 trigger  in  1  measurement request (level), held by the requester until triggerSuc is seen.
REQ-009 triggerSuc  out  1  one-cycle pulse: sensor trigger pulse completed.
REQ-010 valid  out  1  one-cycle pulse: distance updated.
REQ-011 distance  out  DisLen+1  last measured distance in DIV units.
REQ-012 timeout  out  1  one-cycle pulse, coincident with valid, on a timed-out measurement.
REQ-013 sonar_trig  out  1  trigger line to the ultrasonic sensor.
REQ-014 echo  in  1  asynchronous echo line from the sensor.
REQ-015 busy  out  1  high in every state except IDLE.

Function
REQ-016 echo SHALL pass through a 2-flop synchronizer (echo_s); edges are detected on echo_s against its previous value, so an echo edge is seen 2-3 cycles after it occurs.
REQ-017 FSM states SHALL be IDLE, TRIG, WAIT_RISE, ECHO and GAP.
REQ-018 IDLE: when trigger=1, go to TRIG next cycle; otherwise stay.
REQ-019 TRIG: sonar_trig SHALL be high for exactly TRIG_CYC consecutive cycles, then low, and the FSM moves to WAIT_RISE.
REQ-020 triggerSuc SHALL be high for exactly the first cycle in WAIT_RISE.
REQ-021 WAIT_RISE: only a rising edge of echo_s moves the FSM to ECHO; an echo already high on entry SHALL be ignored until it falls and rises again.
REQ-022 ECHO: a sub-counter SHALL count 0..DIV-1 on every echo_s-high cycle; each wrap increments a distance accumulator, which saturates at all-ones.
REQ-023 The accumulator and sub-counter SHALL clear on entry to ECHO.
REQ-024 In ECHO, a falling edge of echo_s SHALL, next cycle, load distance = floor(high cycles / DIV), pulse valid with timeout=0, and enter GAP.
REQ-025 In WAIT_RISE with no rising edge for TIMEOUT_CYC cycles: load distance = all-ones, pulse valid and timeout together, enter GAP.
REQ-026 In ECHO with echo_s still high after TIMEOUT_CYC cycles: load distance = all-ones, pulse valid and timeout together, enter GAP.
REQ-027 If the echo falling edge and timeout expiry fall on the same cycle, the falling edge SHALL win: normal valid, timeout=0.
REQ-028 GAP: stay exactly GAP_CYC cycles, then go to IDLE; trigger is ignored in every state except IDLE.
REQ-029 If trigger is still high on return to IDLE, a new measurement SHALL start with no extra delay.
REQ-030 distance SHALL hold its value between valid pulses.
REQ-031 All outputs SHALL be registered.

Reset
REQ-032 While rst_n=0 at a clk edge: FSM to IDLE; all counters, the synchronizer and the accumulator clear; outputs take their reset values on that edge.
REQ-033 Output reset values: sonar_trig=0, triggerSuc=0, valid=0, timeout=0, busy=0, distance=0.
REQ-034 A reset asserted mid-TRIG SHALL drop sonar_trig at the same edge, and no valid SHALL follow.

Verification
Bench parameters for all scenarios: TRIG_CYC=4, DIV=3, TIMEOUT_CYC=100, GAP_CYC=10, DisLen=7.
REQ-035 Nominal: trigger held high, echo rises 5 cycles after triggerSuc and stays high 30 cycles -> sonar_trig high 4 cycles, one triggerSuc, valid once with distance=10, timeout=0.
REQ-036 Rounding: echo high for 32 cycles -> distance=10.
REQ-037 No echo: echo stays low -> valid and timeout together 100 cycles after WAIT_RISE entry, distance=255.
REQ-038 Stuck echo: echo high at triggerSuc and held high -> no ECHO entry, timeout after 100 cycles, distance=255.
REQ-039 Back-to-back: trigger held high -> second sonar_trig rises exactly 11 cycles after the first valid (10 GAP cycles, then 1 IDLE cycle), never earlier.
REQ-040 Reset mid-ECHO: rst_n=0 for 1 cycle -> busy=0 and distance=0 next cycle, no valid pulse follows.
